// File: rtl/shift_word_feeder.sv
// Serializes a parallel word onto a bidirectional shift register's d/left inputs.
// Optional downstream load check is compiled in with SHIFT_WORD_CHECK_EN.
module shift_word_feeder #(
  parameter int   WIDTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
`ifdef SHIFT_WORD_CHECK_EN
  input  logic [WIDTH-1:0] q_in,
  output logic             load_err,
`endif
  output logic             in_ready,
  output logic             d,
  output logic             left,
  output logic             busy,
  output logic             word_loaded
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_buf;
  logic             r_d;
  logic             r_left;
  logic             r_word_loaded;
  logic             w_accept;

`ifdef SHIFT_WORD_CHECK_EN
  logic [WIDTH-1:0] r_word;
  logic             r_load_err;
  assign load_err = r_load_err;
`endif

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign d           = r_d;
  assign left        = r_left;
  assign busy        = (r_state != S_IDLE);
  assign word_loaded = r_word_loaded;

  // The buffer shifts toward the exit end each bit, so the next bit is always
  // at a fixed position next to the one already presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_buf         <= '0;
      r_d           <= IDLE_BIT;
      r_left        <= 1'b0;
      r_word_loaded <= 1'b0;
`ifdef SHIFT_WORD_CHECK_EN
      r_word        <= '0;
      r_load_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_d           <= IDLE_BIT;
          r_word_loaded <= 1'b0;
          if (w_accept) begin
            r_buf   <= in_data;
            r_left  <= in_dir;
            r_d     <= in_dir ? in_data[WIDTH-1] : in_data[0];
            r_cnt   <= CW'(1);
            r_state <= S_SHIFT;
`ifdef SHIFT_WORD_CHECK_EN
            r_word  <= in_data;
`endif
          end
        end
        S_SHIFT: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_d           <= IDLE_BIT;
            r_word_loaded <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_d   <= r_left ? r_buf[WIDTH-2] : r_buf[1];
            r_buf <= r_left ? (r_buf << 1) : (r_buf >> 1);
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_word_loaded <= 1'b0;
          r_state       <= S_IDLE;
`ifdef SHIFT_WORD_CHECK_EN
          if (q_in != r_word) r_load_err <= 1'b1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_word_feeder.sv
// Directed bench for shift_word_feeder with a behavioural downstream shift register.
module tb_shift_word_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_dir;
  logic       in_ready;
  logic       d;
  logic       left;
  logic       busy;
  logic       word_loaded;
  logic [3:0] q = 4'b0000;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

`ifdef SHIFT_WORD_CHECK_EN
  logic       load_err;
  logic       force_en = 1'b0;
  logic [3:0] q_force  = 4'b0000;
  logic [3:0] q_in_w;
  assign q_in_w = force_en ? q_force : q;
`endif

  shift_word_feeder #(.WIDTH(4), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_dir     (in_dir),
`ifdef SHIFT_WORD_CHECK_EN
    .q_in       (q_in_w),
    .load_err   (load_err),
`endif
    .in_ready   (in_ready),
    .d          (d),
    .left       (left),
    .busy       (busy),
    .word_loaded(word_loaded)
  );

  always #5 clk = ~clk;

  // Downstream bidirectional shift register fed by d/left.
  always @(posedge clk) q <= left ? {q[2:0], d} : {d, q[3:1]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // seq holds the expected d bits in presentation order, first bit in seq[3].
  task automatic send_word(input logic [3:0] data, input logic dir, input logic [3:0] seq);
    @(negedge clk);
    in_valid = 1'b1; in_data = data; in_dir = dir;
    check("ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_data = 4'b0000; in_dir = ~dir;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("d_bit", d, seq[3-k]);
      check("left_shift", left, dir);
      check("busy_shift", busy, 1);
      check("wl_low", word_loaded, 0);
      check("ready_shift", in_ready, 0);
    end
    @(negedge clk);
    check("wl_done", word_loaded, 1);
    check("q_done", q, data);
    check("d_idle_done", d, 0);
    check("left_done", left, dir);
    check("busy_done", busy, 1);
    check("ready_done", in_ready, 0);
    @(negedge clk);
    check("wl_after", word_loaded, 0);
    check("busy_after", busy, 0);
    check("ready_after", in_ready, 1);
    check("left_hold", left, dir);
    check("d_idle_after", d, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_acc, a1, a2, p1, p2, n_pulse, n_low, n_bad_wl;
    logic [3:0] q1, q2;

    rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; in_dir = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_ready", in_ready, 0);
      check("rst_d", d, 0);
      check("rst_left", left, 0);
      check("rst_wl", word_loaded, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; in_valid = 1'b0;

    send_word(4'b1011, 1'b1, 4'b1011);
    send_word(4'b1011, 1'b0, 4'b1101);

    // Back-to-back with in_valid held high.
    n_acc = 0; a1 = 0; a2 = 0; p1 = 0; p2 = 0; n_pulse = 0; n_low = 0;
    q1 = '0; q2 = '0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b0110; in_dir = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (n_acc >= 2) in_valid = 1'b0;
      else if (n_acc == 1) begin in_data = 4'b1001; in_dir = 1'b0; end
      if (word_loaded) begin
        n_pulse++;
        if (n_pulse == 1) begin p1 = c; q1 = q; end
        else begin p2 = c; q2 = q; end
      end
      if (!in_ready && n_acc == 1) n_low++;
      if (in_ready && in_valid) begin
        n_acc++;
        if (n_acc == 1) a1 = c; else a2 = c;
      end
    end
    check("b2b_accepts", n_acc, 2);
    check("b2b_accept_gap", a2 - a1, 6);
    check("b2b_ready_low", n_low, 5);
    check("b2b_pulses", n_pulse, 2);
    check("b2b_latency", p1 - a1, 5);
    check("b2b_pulse_gap", p2 - p1, 6);
    check("b2b_q1", q1, 4'b0110);
    check("b2b_q2", q2, 4'b1001);
    in_valid = 1'b0;

    // Reset after two bits of a word.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1111; in_dir = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_d0", d, 1);
    @(negedge clk);
    check("mid_d1", d, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_d", d, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wl", word_loaded, 0);
    check("mid_rst_left", left, 0);
    check("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    n_bad_wl = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (word_loaded) n_bad_wl++;
    end
    check("mid_no_wl", n_bad_wl, 0);
    send_word(4'b0101, 1'b0, 4'b1010);

`ifdef SHIFT_WORD_CHECK_EN
    check("err_clean", load_err, 0);
    force_en = 1'b1; q_force = 4'b0000;
    send_word(4'b1011, 1'b1, 4'b1011);
    check("err_set", load_err, 1);
    force_en = 1'b0;
    send_word(4'b0110, 1'b0, 4'b0110);
    check("err_sticky", load_err, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("err_rst", load_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
